// File: rtl/div_unit.sv
// Multi-cycle RV32M divide/remainder unit.
// Radix-2 restoring divider with sign fix-up and early-out special cases.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_start,
  input  logic [2:0]      div_op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [5:0] LAST = 6'(XLEN-1);

  state_t state, state_nxt;

  logic [1:0]      op;
  logic [4:0]      rd;
  logic            sa, sb;
  logic [XLEN-1:0] quo, rem, dvs;
  logic [5:0]      cnt;

  logic            acc, dz, ovf, sgn;
  logic [XLEN-1:0] a_abs, b_abs, spc_val, fix_val;
  logic [XLEN:0]   rsh, diff;

  assign sgn = ~div_op[0];
  assign acc = (state == IDLE) && div_start && div_op[2] && !kill;
  assign dz  = (rs2_val == '0);
  assign ovf = sgn && (rs1_val == MIN_NEG) && (rs2_val == '1);

  assign a_abs = (sgn && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
  assign b_abs = (sgn && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;

  // Divide-by-zero wins over overflow; they cannot overlap anyway.
  assign spc_val = dz ? (div_op[1] ? rs1_val : '1)
                      : (div_op[1] ? '0 : MIN_NEG);

  assign rsh  = {rem, quo[XLEN-1]};
  assign diff = rsh - {1'b0, dvs};

  always_comb begin
    fix_val = quo;
    unique case (op)
      2'b00: fix_val = (sa ^ sb) ? -quo : quo;
      2'b01: fix_val = quo;
      2'b10: fix_val = sa ? -rem : rem;
      2'b11: fix_val = rem;
      default: fix_val = quo;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (acc) state_nxt = (dz || ovf) ? DONE : CALC;
        CALC: if (cnt == LAST) state_nxt = FIX;
        FIX:  state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= '0;
      rd     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      result <= '0;
      rd_out <= '0;
    end else if (!kill) begin
      if (acc) begin
        op  <= div_op[1:0];
        rd  <= rd_in;
        sa  <= rs1_val[XLEN-1];
        sb  <= rs2_val[XLEN-1];
        quo <= a_abs;
        dvs <= b_abs;
        rem <= '0;
        cnt <= '0;
        if (dz || ovf) begin
          result <= spc_val;
          rd_out <= rd_in;
        end
      end else if (state == CALC) begin
        cnt <= cnt + 6'd1;
        if (!diff[XLEN]) begin
          rem <= diff[XLEN-1:0];
          quo <= {quo[XLEN-2:0], 1'b1};
        end else begin
          rem <= rsh[XLEN-1:0];
          quo <= {quo[XLEN-2:0], 1'b0};
        end
      end else if (state == FIX) begin
        result <= fix_val;
        rd_out <= rd;
      end
    end
  end

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit.
// Table-driven vectors plus hand sequences for kill, reset and hold cases.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_start;
  logic [2:0]  div_op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } sb_t;

  vec_t vt[14];
  sb_t  sbq[$];

  div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_start (div_start),
    .div_op    (div_op),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .rd_in     (rd_in),
    .kill      (kill),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic run(input logic [2:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [4:0] rd,
                     input logic [31:0] exp,
                     input int lat);
    int  cyc;
    int  nb;
    sb_t e;
    @(negedge clk);
    div_start = 1'b1;
    div_op    = op;
    rs1_val   = a;
    rs2_val   = b;
    rd_in     = rd;
    @(posedge clk);
    sbq.push_back('{res: exp, rd: rd});
    #1;
    cyc = 1;
    nb  = 0;
    while (!done && cyc < 60) begin
      if (busy) nb++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency", 32'(cyc), 32'(lat));
    check("busy_cycles", 32'(nb), (lat == 1) ? 32'd0 : 32'd33);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("result", result, e.res);
      check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
    end
    // div_start still high across the DONE cycle: must be ignored.
    @(posedge clk);
    #1;
    check("done_pulse", {31'd0, done}, 32'd0);
    check("no_accept_in_done", {31'd0, busy}, 32'd0);
    div_start = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int          dcnt;
    int          bcnt;
    logic [31:0] prev_res;
    logic [4:0]  prev_rd;

    vt[0]  = '{3'b100, 32'd20,        32'hFFFFFFFD, 32'hFFFFFFFA, 34};
    vt[1]  = '{3'b110, 32'd20,        32'hFFFFFFFD, 32'h00000002, 34};
    vt[2]  = '{3'b110, 32'hFFFFFFEC,  32'd3,        32'hFFFFFFFE, 34};
    vt[3]  = '{3'b101, 32'hFFFFFFFF,  32'd7,        32'h24924924, 34};
    vt[4]  = '{3'b100, 32'd5,         32'd0,        32'hFFFFFFFF, 1};
    vt[5]  = '{3'b111, 32'd5,         32'd0,        32'h00000005, 1};
    vt[6]  = '{3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1};
    vt[7]  = '{3'b110, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1};
    vt[8]  = '{3'b101, 32'd100,       32'd10,       32'd10,       34};
    vt[9]  = '{3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 34};
    vt[10] = '{3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 34};
    vt[11] = '{3'b101, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 34};
    vt[12] = '{3'b111, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 34};
    vt[13] = '{3'b111, 32'hFFFFFFFF,  32'd7,        32'h00000003, 34};

    rst_n     = 1'b0;
    div_start = 1'b0;
    div_op    = 3'b000;
    rs1_val   = '0;
    rs2_val   = '0;
    rd_in     = '0;
    kill      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 32'd0);
    check("rst_rd", {27'd0, rd_out}, 32'd0);
    check("rst_flags", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run(vt[i].op, vt[i].a, vt[i].b, 5'(i + 1),
          vt[i].exp, vt[i].lat);
    end

    // kill around iteration 10
    prev_res = 32'h00000003;
    prev_rd  = 5'd14;
    @(negedge clk);
    div_start = 1'b1;
    div_op    = 3'b100;
    rs1_val   = 32'd100;
    rs2_val   = 32'd7;
    rd_in     = 5'd9;
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("busy_before_kill", {31'd0, busy}, 32'd1);
    kill      = 1'b1;
    div_start = 1'b0;
    @(posedge clk);
    #1;
    check("kill_flags", {30'd0, busy, done}, 32'd0);
    check("kill_result", result, prev_res);
    check("kill_rd", {27'd0, rd_out}, {27'd0, prev_rd});
    kill = 1'b0;
    dcnt = 0;
    bcnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    check("kill_no_done", 32'(dcnt), 32'd0);
    check("kill_no_busy", 32'(bcnt), 32'd0);

    // invalid op held in IDLE
    @(negedge clk);
    div_start = 1'b1;
    div_op    = 3'b010;
    bcnt = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (busy || done) bcnt++;
    end
    check("invalid_ignored", 32'(bcnt), 32'd0);
    div_start = 1'b0;

    // async reset mid-CALC
    @(negedge clk);
    div_start = 1'b1;
    div_op    = 3'b101;
    rs1_val   = 32'd1000;
    rs2_val   = 32'd3;
    rd_in     = 5'd17;
    @(posedge clk);
    #1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    div_start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_result", result, 32'd0);
    check("arst_rd", {27'd0, rd_out}, 32'd0);
    check("arst_flags", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(3'b101, 32'd1000, 32'd3, 5'd21, 32'd333, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle RV32M divide/remainder unit sitting directly downstream of the instruction decoder. Accepts a divide request (`div_start`, `div_op`, operands, destination tag) when idle, runs a 32-iteration radix-2 restoring division, and returns a sign-corrected quotient or remainder with a one-cycle `done` pulse. While it works, `busy` tells the pipeline to hold the divide instruction.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `div_start`  in  1  request from decoder; level, held while the instruction is stalled.
- `div_op`  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; `div_op[2]=0` is invalid.
- `rs1_val`  in  32  dividend.
- `rs2_val`  in  32  divisor.
- `rd_in`  in  5  destination register tag.
- `kill`  in  1  synchronous abort (pipeline flush).
- `busy`  out  1  high in CALC and FIX.
- `done`  out  1  one-cycle pulse; `result` and `rd_out` valid.
- `result`  out  32  quotient or remainder; held until the next acceptance.
- `rd_out`  out  5  tag captured at acceptance.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **Acceptance.** A request is accepted only in IDLE, on an edge where `div_start=1`, `div_op[2]=1` and `kill=0`. At acceptance the unit latches:
  - the op, `rd_in`, and the operand signs;
  - operand magnitudes for DIV/REM (two's-complement negate when bit 31 is set);
  - raw operands for DIVU/REMU.
- **Special cases at acceptance** (state goes IDLE→DONE, `result` loaded directly):
  - Divisor = 0: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = `rs1_val` (REM and REMU).
  - DIV/REM with `rs1_val`=0x80000000 and `rs2_val`=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- **Normal path.** IDLE→CALC with a 6-bit counter at 0.
  - Each CALC edge: `{rem,quo}` shifts left 1, then trial-subtract the divisor from `rem`.
  - If the trial is non-negative: keep the difference and set `quo[0]=1`.
  - After the 32nd iteration (counter = 31), go to FIX.
- **FIX edge.** Load `result`:
  - DIV: negate the quotient if sign(a) XOR sign(b).
  - REM: negate the remainder if sign(a).
  - Unsigned ops: no correction.
  - State goes to DONE.
- **DONE.** `done=1` for exactly one cycle, then IDLE. A request sampled in DONE is ignored; the pipeline releases its stall on `done` and must present the next instruction in the following cycle.
- **Ignored requests.** `div_start` in CALC/FIX/DONE is ignored. An invalid `div_op` in IDLE is ignored; the state stays IDLE.
- **kill.** In any state, the next edge goes to IDLE with `done=0` and `busy=0`. `result` and `rd_out` keep their previous values. `kill` has priority over acceptance.
- **Reset.** Asserting `rst_n` low at any time, including mid-CALC, immediately forces:
  - state to IDLE;
  - counter, `busy`, `done`, `result`, `rd_out` and all internal registers to 0.

## Timing
- Acceptance edge E0.
- Normal op: CALC occupies E1..E32, FIX at E33. `done` is high in the cycle after E33, giving 34 cycles from acceptance to `done`. `busy` is high from after E0 until the FIX→DONE edge.
- Special case: `done` is high in the cycle after E0. `busy` is never asserted.
- Back-to-back: the earliest next acceptance is on the edge ending the DONE cycle+1, i.e. in IDLE.
- `result`/`rd_out` change only at the FIX edge or at a special-case acceptance edge; they are registered outputs.
- Outputs are 0 after reset until the first completion.

## Test plan
- DIV 20 / −3 (0x00000014, 0xFFFFFFFD) → `result`=0xFFFFFFFA. `done` appears 34 cycles after acceptance, and `busy` is high for cycles 1–33.
- REM 20 % −3 → 0x00000002. REM −20 % 3 → 0xFFFFFFFE.
- DIVU 0xFFFFFFFF / 7 → 0x24924924. REMU of the same operands → 0x00000003.
- Divisor zero:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 0x00000005.
  - Both pulse `done` in the cycle after acceptance, with `busy` never high.
- Overflow:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0x00000000.
  - Both complete in 1 cycle.
- Abort and reset:
  - Assert `kill` during CALC iteration 10 → IDLE next edge, no `done`, `result` unchanged.
  - Drive `rst_n` low during CALC (async, mid-cycle) → all outputs 0 immediately.
  - Hold `div_start` high while busy, then a fresh request after IDLE → only one completion per accepted request.
